// File: rtl/ssd_driver.sv
// ssd_driver: binary-to-BCD display back-end for a 4-digit common-anode
// seven-segment display.
//   A sequential double-dabble engine converts value_i into four BCD digits.
//   A free-running refresh counter selects which digit is driven.
//
// Ports:
//   clk      system clock
//   rst      asynchronous, active-low reset
//   value_i  unsigned binary value to display
//   anode_o  digit enables, active-low; bit 0 is the ones digit
//   seg_o    segments {g,f,e,d,c,b,a}, active-low
//   dp_o     decimal point, active-low; held off
//   busy_o   high while a conversion is in progress
//
// Optional feature:
//   Define SSD_BLANK_EN to enable leading-zero blanking.
//   When it is not defined, the display shows all four digits with zero padding.
module ssd_driver #(
    parameter int unsigned CNT_W = 20,
    parameter int unsigned VAL_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] value_i,
    output logic [3:0]       anode_o,
    output logic [6:0]       seg_o,
    output logic             dp_o,
    output logic             busy_o
);

    localparam int unsigned BCD_W = 16;
    localparam int unsigned SH_W  = BCD_W + VAL_W;
    localparam int unsigned IT_W  = $clog2(VAL_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [VAL_W-1:0] val_q, val_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic [IT_W-1:0]  it_q, it_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             busy_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       digit;
    logic [3:0]       nib_c;
    logic             blank_c;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [SH_W-1:0] dabble(input logic [SH_W-1:0] s);
        logic [SH_W-1:0] t;
        t = s;
        for (int i = 0; i < 4; i++) begin
            if (t[VAL_W+4*i +: 4] >= 4'd5)
                t[VAL_W+4*i +: 4] = t[VAL_W+4*i +: 4] + 4'd3;
        end
        return {t[SH_W-2:0], 1'b0};
    endfunction

    // Active-low seven-segment decode. Codes 10 to 15 show a blank digit.
    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Converter state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            val_q   <= '0;
            sh_q    <= '0;
            it_q    <= '0;
            bcd_q   <= '0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            sh_q    <= sh_d;
            it_q    <= it_d;
            bcd_q   <= bcd_d;
            busy_o  <= busy_d;
        end
    end

    // Converter next state. bcd_q is loaded only in DONE, so all four digits change together.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        sh_d    = sh_q;
        it_d    = it_q;
        bcd_d   = bcd_q;
        busy_d  = busy_o;
        case (state_q)
            IDLE: begin
                if (value_i != val_q) begin
                    val_d   = value_i;
                    sh_d    = {16'h0000, value_i};
                    it_d    = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sh_d = dabble(sh_q);
                it_d = it_q + IT_W'(1);
                if (it_q == IT_W'(VAL_W - 1))
                    state_d = DONE;
            end
            DONE: begin
                bcd_d   = sh_q[SH_W-1 -: BCD_W];
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running refresh counter. Its top two bits select the digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_q + CNT_W'(1);
    end

    assign digit = cnt_q[CNT_W-1 -: 2];

    // Select the nibble for the current digit
    always_comb begin
        nib_c = bcd_q[3:0];
        case (digit)
            2'd0: nib_c = bcd_q[3:0];
            2'd1: nib_c = bcd_q[7:4];
            2'd2: nib_c = bcd_q[11:8];
            2'd3: nib_c = bcd_q[15:12];
            default: nib_c = bcd_q[3:0];
        endcase
    end

`ifdef SSD_BLANK_EN
    logic lz3_c, lz2_c, lz1_c;

    // A digit is blanked when it and every higher digit are zero. The ones digit always shows.
    always_comb begin
        lz3_c   = (bcd_q[15:12] == 4'd0);
        lz2_c   = lz3_c && (bcd_q[11:8] == 4'd0);
        lz1_c   = lz2_c && (bcd_q[7:4] == 4'd0);
        blank_c = 1'b0;
        case (digit)
            2'd1: blank_c = lz1_c;
            2'd2: blank_c = lz2_c;
            2'd3: blank_c = lz3_c;
            default: blank_c = 1'b0;
        endcase
    end
`else
    assign blank_c = 1'b0;
`endif

    // Registered display outputs. They lag the refresh counter by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode_o <= 4'b1111;
            seg_o   <= 7'b1111111;
            dp_o    <= 1'b1;
        end else begin
            anode_o <= blank_c ? 4'b1111 : ~(4'b0001 << digit);
            seg_o   <= blank_c ? 7'b1111111 : decode(nib_c);
            dp_o    <= 1'b1;
        end
    end

endmodule
